// File: rtl/uart_tx_queue.sv
// Byte FIFO that feeds a UART transmitter through a send/busy handshake.
// Define UART_TXQ_OVERFLOW_FLAG_EN to enable the sticky overflow flag.
module uart_tx_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        overflow,
    input  logic        ovf_clear
);
    typedef enum logic [1:0] {IDLE, REQ, XMIT} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, drop;

    // full is the pre-pop view, so a push into a full queue is dropped even if a pop frees a slot
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign drop    = wr_en && full;
    assign tx_send = (state == REQ);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ:     if (tx_busy)  state_nxt = XMIT;
            XMIT:    if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_data <= 8'h00;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clear ^ drop;
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple 10-cycle-busy transmitter model.
module tb_uart_tx_queue;
    logic       clk = 1'b0;
    logic       reset, wr_en, ovf_clear, busy_drv, model_en;
    logic [7:0] wr_data;
    logic       full, empty, tx_send, tx_busy, overflow;
    logic [3:0] count;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    logic send_q = 1'b0;
    logic [7:0] launch_data [$];
    int         launch_cyc [$];

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    uart_tx_queue #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .tx_data(tx_data),
        .tx_send(tx_send), .tx_busy(tx_busy), .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    // Transmitter: busy for 10 cycles starting the edge after it sees send.
    assign tx_busy = model_en ? (busy_cnt != 0) : busy_drv;
    always @(posedge clk) begin
        if (!model_en)         busy_cnt <= 0;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (tx_send)       busy_cnt <= 10;
    end

    // Launch monitor: one record per rising edge of tx_send.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_send && !send_q) begin
            launch_data.push_back(tx_data);
            launch_cyc.push_back(cyc);
        end
        send_q <= tx_send;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld(input int i);
        if (i < launch_data.size()) return {24'h0, launch_data[i]};
        return 'x;
    endfunction

    function automatic logic [31:0] lc(input int i);
        if (i < launch_cyc.size()) return launch_cyc[i];
        return 'x;
    endfunction

    initial begin
        int n0;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clear = 1'b0;
        busy_drv = 1'b0; model_en = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_send", tx_send, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_ovf", overflow, 0);
        step(); step();
        reset = 1'b0;

        // Single byte: send two cycles after push, drop on busy
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("p1_count", count, 1);
        check("p1_send_early", tx_send, 0);
        step();
        check("p1_send", tx_send, 1);
        check("p1_data", tx_data, 8'hA5);
        check("p1_empty", empty, 1);
        busy_drv = 1'b1;
        step();
        check("p1_send_drop", tx_send, 0);
        check("p1_empty2", empty, 1);
        check("p1_data_hold", tx_data, 8'hA5);
        busy_drv = 1'b0;
        step();

        // Three bytes against the 10-cycle transmitter: launches 13 edges apart
        n0 = launch_data.size();
        model_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            step();
        end
        wr_en = 1'b0;
        for (int g = 0; g < 80 && launch_data.size() < n0 + 3; g++) step();
        for (int g = 0; g < 20; g++) step();
        check("seq_launches", launch_data.size() - n0, 3);
        check("seq_b0", ld(n0), 8'h01);
        check("seq_b1", ld(n0 + 1), 8'h02);
        check("seq_b2", ld(n0 + 2), 8'h03);
        check("seq_gap1", lc(n0 + 1) - lc(n0), 13);
        check("seq_gap2", lc(n0 + 2) - lc(n0 + 1), 13);
        check("seq_empty", empty, 1);

        // Fill with transmitter stuck busy; 9th push dropped
        model_en = 1'b0; busy_drv = 1'b1;
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            step();
        end
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_ovf0", overflow, 0);
        wr_data = 8'h18;
        step();
        wr_en = 1'b0;
        check("drop_count", count, 8);
        check("drop_full", full, 1);
        check("drop_ovf", overflow, OVF);
        check("drop_nopop", tx_data, 8'h00);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_clear", overflow, 0);
        wr_en = 1'b1; wr_data = 8'h19; ovf_clear = 1'b1;
        step();
        wr_en = 1'b0; ovf_clear = 1'b0;
        check("ovf_set_wins", overflow, OVF);
        check("ovf_set_count", count, 8);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_clear2", overflow, 0);

        // Push+pop on full: push dropped, count 7; then 20 bytes through with wrap
        n0 = launch_data.size();
        busy_drv = 1'b0; model_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        check("pp_count", count, 7);
        check("pp_full", full, 0);
        check("pp_send", tx_send, 1);
        check("pp_data", tx_data, 8'h10);
        for (int b = 0; b < 12; b++) begin
            for (int g = 0; g < 100 && full; g++) step();
            wr_en = 1'b1; wr_data = 8'(8'h18 + b);
            step();
            wr_en = 1'b0;
        end
        for (int g = 0; g < 600 && launch_data.size() < n0 + 20; g++) step();
        for (int g = 0; g < 20; g++) step();
        check("wrap_launches", launch_data.size() - n0, 20);
        for (int i = 0; i < 20; i++) check($sformatf("wrap_b%0d", i), ld(n0 + i), 8'h10 + i);
        check("wrap_empty", empty, 1);

        // Reset while in XMIT with four bytes queued
        model_en = 1'b0; busy_drv = 1'b0;
        n0 = launch_data.size();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
            step();
        end
        wr_en = 1'b0; busy_drv = 1'b1;
        step();
        check("xm_count", count, 4);
        check("xm_send", tx_send, 0);
        check("xm_data", tx_data, 8'hA0);
        #2 reset = 1'b1;
        #1;
        check("xrst_count", count, 0);
        check("xrst_empty", empty, 1);
        check("xrst_send", tx_send, 0);
        step(); step();
        reset = 1'b0; busy_drv = 1'b0;
        for (int g = 0; g < 30; g++) step();
        check("xrst_launches", launch_data.size() - n0, 1);
        check("xrst_send_after", tx_send, 0);
        check("xrst_empty_after", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
